// File: rtl/rr_grant_scheduler_8.sv
// Round-robin scheduler for one resource shared by 8 requesters.
// Grant is held while the winner keeps requesting, optionally capped at
// MAX_HOLD cycles; every release leaves one idle cycle before re-arbitration.
module rr_grant_scheduler_8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  // Hold limit expressed as the hcnt value seen on the revoke edge.
  localparam logic [7:0] LP_LIM     = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam bit         LP_LIMITED = (MAX_HOLD != 0);

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_hcnt;
  logic [7:0] r_grant;
  logic [2:0] r_grant_idx;
  logic       r_grant_valid;
  logic       r_timeout;

  logic       w_found;
  logic [2:0] w_pick;
  logic       w_req_k;
  logic       w_limit;

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

  assign w_req_k = req[r_grant_idx];
  assign w_limit = LP_LIMITED && (r_hcnt == LP_LIM);

  // Circular priority search starting at r_ptr; scanning the offsets downward
  // lets the smallest offset with a request win.
  always_comb begin
    logic [2:0] v_idx;
    w_found = 1'b0;
    w_pick  = r_ptr;
    v_idx   = r_ptr;
    for (int i = 7; i >= 0; i--) begin
      v_idx = r_ptr + 3'(i);
      if (req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end
    end
  end

  // Scheduler FSM: arbitrate in IDLE, hold / release / time out in GRANT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= 3'd0;
      r_hcnt        <= 8'd0;
      r_grant       <= 8'h00;
      r_grant_idx   <= 3'd0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && w_found) begin
            r_grant_idx   <= w_pick;
            r_grant       <= 8'(1) << w_pick;
            r_grant_valid <= 1'b1;
            r_hcnt        <= 8'd0;
            r_state       <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!w_req_k || w_limit) begin
            // Voluntary release takes precedence, so timeout only fires
            // when the requester is still asking at the limit.
            r_timeout     <= w_req_k;
            r_grant       <= 8'h00;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= 3'd0;
            r_ptr         <= r_grant_idx + 3'd1;
            r_state       <= S_IDLE;
          end else if (r_hcnt != 8'hFF) begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_scheduler_8.sv
// Directed bench: a MAX_HOLD=4 instance and an unlimited (MAX_HOLD=0)
// instance share all inputs; expected values are hand-computed.
module tb_rr_grant_scheduler_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] grant,  grant0;
  logic [2:0] idx,    idx0;
  logic       vld,    vld0;
  logic       tmo,    tmo0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_grant_scheduler_8 #(.MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(grant), .grant_idx(idx), .grant_valid(vld), .timeout(tmo)
  );

  rr_grant_scheduler_8 #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(grant0), .grant_idx(idx0), .grant_valid(vld0), .timeout(tmo0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output check of the MAX_HOLD=4 instance.
  task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] i,
                         input logic v, input logic t);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".idx"},   32'(idx),   32'(i));
    chk({tag, ".valid"}, 32'(vld),   32'(v));
    chk({tag, ".tmo"},   32'(tmo),   32'(t));
  endtask

  initial begin
    // ---- reset state
    tick();
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    chk("reset0.grant", 32'(grant0), 32'h0);

    // ---- test 1: single request, one-cycle latency, release
    rst = 1'b0; en = 1'b1; req = 8'h04;
    tick();
    chk_all("t1.grant", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_all("t1.rel", 8'h00, 3'd0, 1'b0, 1'b0);

    // ---- test 2: ptr=3, search wraps to 0, then 2 next
    req = 8'h05;
    tick();
    chk_all("t2.wrap", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h04;
    tick();
    chk_all("t2.bubble", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_all("t2.next", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk("t2.rel", 32'(vld), 32'h0);

    // ---- test 3: all request, 4-cycle grants rotate 0..7,0 with timeouts
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_all($sformatf("t3.g%0d.c%0d", g, c), 8'(1) << (g % 8), 3'(g % 8), 1'b1, 1'b0);
      end
      tick();
      chk_all($sformatf("t3.g%0d.revoke", g), 8'h00, 3'd0, 1'b0, 1'b1);
    end

    // ---- test 4: lone requester 5, timeout then regrant; drop at limit
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h20;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_all($sformatf("t4.c%0d", c), 8'h20, 3'd5, 1'b1, 1'b0);
    end
    tick();
    chk_all("t4.revoke", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    chk_all("t4.regrant", 8'h20, 3'd5, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk_all("t4.c4th", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_all("t4.dropnotmo", 8'h00, 3'd0, 1'b0, 1'b0);

    // ---- test 5: reset mid-grant, then ptr back to 0
    req = 8'h10;
    tick();
    chk_all("t5.grant", 8'h10, 3'd4, 1'b1, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_all("t5.rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0; req = 8'h90;
    tick();
    chk_all("t5.after", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk("t5.rel", 32'(vld), 32'h0);

    // ---- test 6: en gating, en=0 keeps an active grant
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b0; req = 8'h01;
    tick();
    chk_all("t6.en0a", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_all("t6.en0b", 8'h00, 3'd0, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    chk_all("t6.en1", 8'h01, 3'd0, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    chk_all("t6.hold1", 8'h01, 3'd0, 1'b1, 1'b0);
    tick();
    chk_all("t6.hold2", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    chk_all("t6.rel", 8'h00, 3'd0, 1'b0, 1'b0);

    // ---- test 6b: unlimited hold for 300 cycles on requester 3
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; req = 8'h08;
    tick();
    chk("t6u.grant", 32'(grant0), 32'h08);
    chk("t6u.idx",   32'(idx0),   32'h3);
    for (int c = 0; c < 300; c++) begin
      tick();
      chk($sformatf("t6u.c%0d.grant", c), 32'(grant0), 32'h08);
      chk($sformatf("t6u.c%0d.tmo", c),   32'(tmo0),   32'h0);
    end
    req = 8'h00;
    tick();
    chk("t6u.rel.grant", 32'(grant0), 32'h00);
    chk("t6u.rel.valid", 32'(vld0),   32'h0);
    chk("t6u.rel.tmo",   32'(tmo0),   32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_scheduler_8.md
Name: rr_grant_scheduler_8

Overview:
- Round-robin scheduler that shares one 8-way resource among 8 requesters.
- The grant is issued as a 3-bit index and as its one-hot 3-to-8 decoded form, so it can directly drive per-requester enables.
- Sits between requester logic and the shared datapath. Adds fairness, grant hold and a hold-time limit on top of the plain decode function.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one grant may stay asserted. 0 = unlimited. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  scheduler enable; when 0, no new grant is issued
- req  input  8  request vector, bit i = requester i
- grant  output  8  one-hot grant, registered; all zeros when idle
- grant_idx  output  3  index of the granted requester; valid only when grant_valid=1
- grant_valid  output  1  1 while any grant is asserted
- timeout  output  1  one-cycle pulse on the cycle a grant is revoked by MAX_HOLD

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0.
  - State IDLE, priority pointer ptr=3'd0, hold counter hcnt=0.
  - Reset overrides everything, including an active grant; grant drops at that edge.
- All outputs are registered. grant always equals the decode of grant_idx gated by grant_valid: bit i=1 exactly when grant_valid=1 and grant_idx=i.
- State IDLE:
  - On an edge with en=1 and req!=0: choose the first set bit of req, searching ptr, ptr+1, ... 7, 0, ... ptr-1 (mod 8).
  - Load grant_idx with that index, set grant_valid=1, set hcnt=0, go to GRANT.
  - Latency from req sampled high to grant visible is 1 cycle.
  - With en=0 or req=0, stay in IDLE with outputs at zero.
- State GRANT, evaluated every edge with k = grant_idx:
  - (a) req[k]=0: release. Clear grant and grant_valid, ptr=k+1 mod 8, go to IDLE.
  - (b) else MAX_HOLD!=0 and hcnt==MAX_HOLD-1: forced release. Clear grant, ptr=k+1 mod 8, timeout=1 for this cycle only, go to IDLE.
  - (c) otherwise: hold. hcnt increments, grant is unchanged.
  - Priority is (a) over (b) over (c). timeout is not asserted when req drops on the same edge as the limit.
- en in GRANT: en=0 does not revoke an active grant. It only blocks new grants from IDLE.
- Bubble: every release (a or b) produces exactly one cycle of grant_valid=0 before the next grant.
- Counter:
  - hcnt is 8 bits and saturates; it never wraps.
  - With MAX_HOLD=0, hcnt is not compared and a grant persists as long as req[k]=1.
- Grant duration: with MAX_HOLD=N>0 and the requester holding req high, grant is asserted for exactly N cycles.
- ptr wrap: grant of index 7 sets ptr=0.
- Input changes: changes of req bits other than k during GRANT have no effect until the next IDLE arbitration.
- Single requester: a lone continuously requesting requester under MAX_HOLD sees N cycles granted, 1 cycle bubble, then is re-granted. The search wraps back to it.

Test Plan:
1. Reset, then req=8'b0000_0100, en=1 → one cycle later grant=8'h04, grant_idx=2, grant_valid=1. Drop req[2] → grant=0 next cycle, ptr=3.
2. ptr=3 (after test 1), req=8'b0000_0101 → grant_idx=0, since the search runs 3..7 then wraps to 0. Release → grant_idx=2 on the following arbitration. Confirms fairness order.
3. MAX_HOLD=4, req=8'hFF held → grant sequence idx 0,1,2,...,7,0. Each grant lasts 4 cycles, followed by 1 idle cycle, with timeout=1 on each revoke edge.
4. MAX_HOLD=4, req[5] only, held → grant=8'h20 for 4 cycles, timeout pulse, 1-cycle gap, then re-granted. Drop req[5] on the 4th cycle → no timeout pulse.
5. Assert rst mid-grant (grant=8'h10, hcnt=2) → next edge grant=0, grant_valid=0, timeout=0, ptr=0. After rst, req=8'h90 → grant_idx=4.
6. en=0 with req=8'h01 → no grant. en=0 during an active grant → grant held. MAX_HOLD=0 with req[3] held 300 cycles → grant=8'h08 throughout, no timeout, hcnt saturated at 255.
